if_spike_decoder: RTL and testbench

- Output-stage decoder placed directly downstream of the IF spiking network.
- Counts the spikes from each output neuron over a fixed inference window of timesteps.
- Scans the counters sequentially to find the winning neuron (argmax) and presents the class index with a valid/ready handshake.
- Issues a one-cycle clear pulse so the network's membrane state is reset at the start of each sample.

---
 rtl/if_spike_decoder.sv | 160 ++++++++++++++++
 tb/tb_if_spike_decoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_spike_decoder.sv
// if_spike_decoder: spike-count argmax decoder for the output layer of an IF spiking network.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   start        begin an inference window (sampled only in IDLE)
//   spike_in     one spike bit per output neuron (counted only in COUNT)
//   net_clear    one-cycle pulse that resets the upstream network
//   busy         high in every state except IDLE
//   result_valid class result available (DONE)
//   result_ready consumer accepts the result
//   class_idx    index of the winning neuron (lowest index on ties)
//   class_count  spike count of the winning neuron
//   tie          another neuron matched the winning count
//   early_exit   result came from a window cut short by EARLY_THRESH
//                (present only with IF_DECODER_EARLY_EXIT_EN defined)
//
// Optional feature macro: IF_DECODER_EARLY_EXIT_EN
module if_spike_decoder #(
    parameter int NUM_OUTPUTS  = 4,
    parameter int COUNT_WIDTH  = 8,
    parameter int WINDOW       = 100,
    parameter int EARLY_THRESH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_OUTPUTS-1:0]         spike_in,
    output logic                           net_clear,
    output logic                           busy,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [$clog2(NUM_OUTPUTS)-1:0] class_idx,
    output logic [COUNT_WIDTH-1:0]         class_count,
    output logic                           tie
`ifdef IF_DECODER_EARLY_EXIT_EN
    ,
    output logic                           early_exit
`endif
);
    localparam int IW = $clog2(NUM_OUTPUTS);
    localparam int TW = WINDOW > 1 ? $clog2(WINDOW) : 1;
    localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

    typedef enum logic [2:0] {IDLE, CLEAR, COUNT, SCAN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q [NUM_OUTPUTS];
    logic [COUNT_WIDTH-1:0] cnt_d [NUM_OUTPUTS];
    logic [TW-1:0]          ts_q, ts_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          class_idx_q, class_idx_d;
    logic [COUNT_WIDTH-1:0] class_count_q, class_count_d;
    logic                   tie_q, tie_d;
    logic [COUNT_WIDTH-1:0] cur;
`ifdef IF_DECODER_EARLY_EXIT_EN
    logic                   early_q, early_d;
    logic                   hit;
`else
    logic                   unused_thresh;
    assign unused_thresh = ^EARLY_THRESH;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '{default: '0};
            ts_q          <= '0;
            idx_q         <= '0;
            class_idx_q   <= '0;
            class_count_q <= '0;
            tie_q         <= 1'b0;
`ifdef IF_DECODER_EARLY_EXIT_EN
            early_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ts_q          <= ts_d;
            idx_q         <= idx_d;
            class_idx_q   <= class_idx_d;
            class_count_q <= class_count_d;
            tie_q         <= tie_d;
`ifdef IF_DECODER_EARLY_EXIT_EN
            early_q       <= early_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ts_d          = ts_q;
        idx_d         = idx_q;
        class_idx_d   = class_idx_q;
        class_count_d = class_count_q;
        tie_d         = tie_q;
        cur           = cnt_q[idx_q];
`ifdef IF_DECODER_EARLY_EXIT_EN
        early_d       = early_q;
        hit           = 1'b0;
`endif
        case (state_q)
            IDLE: state_d = start ? CLEAR : IDLE;
            CLEAR: begin
                cnt_d   = '{default: '0};
                ts_d    = '0;
                idx_d   = '0;
`ifdef IF_DECODER_EARLY_EXIT_EN
                early_d = 1'b0;
`endif
                state_d = COUNT;
            end
            COUNT: begin
                // Saturating increment: a full counter stays at its maximum.
                for (int i = 0; i < NUM_OUTPUTS; i++)
                    cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(spike_in[i] && cnt_q[i] != CMAX);
                ts_d = ts_q + 1'b1;
`ifdef IF_DECODER_EARLY_EXIT_EN
                // Threshold is checked on the post-increment value so the spike
                // sampled this cycle can end the window.
                for (int i = 0; i < NUM_OUTPUTS; i++)
                    if (32'(cnt_d[i]) >= EARLY_THRESH) hit = 1'b1;
                early_d = early_q | hit;
                state_d = (ts_q == TW'(WINDOW - 1) || hit) ? SCAN : COUNT;
`else
                state_d = ts_q == TW'(WINDOW - 1) ? SCAN : COUNT;
`endif
            end
            SCAN: begin
                // Strict greater-than keeps the lowest index on equal counts.
                if (idx_q == '0) begin
                    class_idx_d   = '0;
                    class_count_d = cur;
                    tie_d         = 1'b0;
                end else if (cur > class_count_q) begin
                    class_idx_d   = idx_q;
                    class_count_d = cur;
                    tie_d         = 1'b0;
                end else if (cur == class_count_q) begin
                    tie_d         = 1'b1;
                end
                idx_d   = idx_q + 1'b1;
                state_d = idx_q == IW'(NUM_OUTPUTS - 1) ? DONE : SCAN;
            end
            DONE: state_d = result_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign net_clear    = state_q == CLEAR;
    assign busy         = state_q != IDLE;
    assign result_valid = state_q == DONE;
    assign class_idx    = class_idx_q;
    assign class_count  = class_count_q;
    assign tie          = tie_q;
`ifdef IF_DECODER_EARLY_EXIT_EN
    assign early_exit   = early_q;
`endif
endmodule

// File: tb/tb_if_spike_decoder.sv
// tb_if_spike_decoder: directed self-checking bench for if_spike_decoder.
// u_dut: NUM_OUTPUTS=4, COUNT_WIDTH=8, WINDOW=10; u_sat: COUNT_WIDTH=3, WINDOW=12.
// Both share start/spike_in/result_ready; u_ee exists only with IF_DECODER_EARLY_EXIT_EN.
module tb_if_spike_decoder;
    logic       clk = 0;
    logic       rst = 0;
    logic       start = 0;
    logic       result_ready = 1;
    logic [3:0] spike_in = '0;

    logic       net_clear1, busy1, rv1, tie1;
    logic [1:0] idx1;
    logic [7:0] cnt1;
    logic       net_clear2, busy2, rv2, tie2;
    logic [1:0] idx2;
    logic [2:0] cnt2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

`ifdef IF_DECODER_EARLY_EXIT_EN
    logic       ee1, ee2, ee3, start3 = 0, ready3 = 0;
    logic       net_clear3, busy3, rv3, tie3;
    logic [1:0] idx3;
    logic [7:0] cnt3;

    if_spike_decoder #(.NUM_OUTPUTS(4), .COUNT_WIDTH(8), .WINDOW(100), .EARLY_THRESH(3)) u_ee (
        .clk(clk), .rst(rst), .start(start3), .spike_in(spike_in), .net_clear(net_clear3),
        .busy(busy3), .result_valid(rv3), .result_ready(ready3), .class_idx(idx3),
        .class_count(cnt3), .tie(tie3), .early_exit(ee3));
`endif

    if_spike_decoder #(.NUM_OUTPUTS(4), .COUNT_WIDTH(8), .WINDOW(10), .EARLY_THRESH(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .net_clear(net_clear1),
        .busy(busy1), .result_valid(rv1), .result_ready(result_ready), .class_idx(idx1),
        .class_count(cnt1), .tie(tie1)
`ifdef IF_DECODER_EARLY_EXIT_EN
        , .early_exit(ee1)
`endif
    );

    if_spike_decoder #(.NUM_OUTPUTS(4), .COUNT_WIDTH(3), .WINDOW(12), .EARLY_THRESH(16)) u_sat (
        .clk(clk), .rst(rst), .start(start), .spike_in(spike_in), .net_clear(net_clear2),
        .busy(busy2), .result_valid(rv2), .result_ready(result_ready), .class_idx(idx2),
        .class_count(cnt2), .tie(tie2)
`ifdef IF_DECODER_EARLY_EXIT_EN
        , .early_exit(ee2)
`endif
    );

    task automatic wait_idle();
        int k = 0;
        while ((busy1 || busy2) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy1 || busy2) begin
            n_fail++;
            $display("FAIL wait_idle: busy1=%0b busy2=%0b, required 0/0", busy1, busy2);
        end
    endtask

    // Holds start until CLEAR is seen (acc = cycles waited), then drives
    // pattern a for the first na COUNT timesteps and b for the rest of
    // timesteps 0..11; all-ones afterwards, which must be ignored.
    // Returns lat = edges from the start edge until result_valid.
    task automatic run(input logic [3:0] a, input int na, input logic [3:0] b,
                       input bit sel, output int acc, output int lat);
        start = 1;
        acc = 0;
        while (!(sel ? net_clear2 : net_clear1) && acc < 8) begin
            @(negedge clk);
            acc++;
        end
        start = 0;
        n_cmp++;
        if (!(sel ? net_clear2 : net_clear1)) begin
            n_fail++;
            $display("FAIL run_clear: net_clear=0 after %0d cycles, required 1", acc);
        end
        lat = 0;
        while (lat < 60) begin
            spike_in = (lat >= 1 && lat <= 12) ? ((lat - 1 < na) ? a : b) : 4'hF;
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                n_cmp++;
                if ((sel ? net_clear2 : net_clear1) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL net_clear_pulse: net_clear=%0b in COUNT, required 0",
                             sel ? net_clear2 : net_clear1);
                end
            end
            if (sel ? rv2 : rv1) break;
        end
        spike_in = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy1, rv1, net_clear1, idx1, cnt1, tie1} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", {busy1, rv1, net_clear1, idx1, cnt1, tie1});
        end
        rst = 1;
        @(negedge clk);
        n_cmp++;
        if ({busy1, rv1} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy/valid=%b, required 00", {busy1, rv1});
        end
    endtask

    task automatic test_single_winner();
        int acc, lat;
        wait_idle();
        result_ready = 1;
        run(4'b0100, 10, 4'b0100, 0, acc, lat);
        n_cmp++;
        if (acc !== 1) begin
            n_fail++;
            $display("FAIL single_start: start accepted after %0d cycles, required 1", acc);
        end
        n_cmp++;
        if (lat !== 15) begin
            n_fail++;
            $display("FAIL single_latency: got %0d, required 15", lat);
        end
        n_cmp++;
        if ({idx1, cnt1, tie1} !== {2'd2, 8'd10, 1'b0}) begin
            n_fail++;
            $display("FAIL single_result: idx=%0d cnt=%0d tie=%0b, required 2/10/0", idx1, cnt1, tie1);
        end
    endtask

    task automatic test_back_to_back();
        int acc, lat;
        run(4'b1010, 5, 4'b0000, 0, acc, lat);
        n_cmp++;
        if (acc !== 2) begin
            n_fail++;
            $display("FAIL b2b_start: start accepted after %0d cycles, required 2", acc);
        end
        n_cmp++;
        if (lat !== 15) begin
            n_fail++;
            $display("FAIL tie_latency: got %0d, required 15", lat);
        end
        n_cmp++;
        if ({idx1, cnt1, tie1} !== {2'd1, 8'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL tie_result: idx=%0d cnt=%0d tie=%0b, required 1/5/1", idx1, cnt1, tie1);
        end
    endtask

    task automatic test_saturation();
        int acc, lat;
        wait_idle();
        run(4'b0101, 6, 4'b0001, 1, acc, lat);
        n_cmp++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL sat_latency: got %0d, required 17", lat);
        end
        n_cmp++;
        if ({idx2, cnt2, tie2} !== {2'd0, 3'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_result: idx=%0d cnt=%0d tie=%0b, required 0/7/0", idx2, cnt2, tie2);
        end
    endtask

    task automatic test_handshake();
        int acc, lat;
        wait_idle();
        result_ready = 0;
        run(4'b1000, 7, 4'b0010, 0, acc, lat);
        n_cmp++;
        if ({idx1, cnt1, tie1} !== {2'd3, 8'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL hs_result: idx=%0d cnt=%0d tie=%0b, required 3/7/0", idx1, cnt1, tie1);
        end
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clk);
            n_cmp++;
            if ({rv1, idx1, cnt1, tie1} !== {1'b1, 2'd3, 8'd7, 1'b0}) begin
                n_fail++;
                $display("FAIL hs_hold%0d: valid=%0b idx=%0d cnt=%0d tie=%0b, required 1/3/7/0",
                         i, rv1, idx1, cnt1, tie1);
            end
        end
        start = 0;
        result_ready = 1;
        @(negedge clk);
        n_cmp++;
        if ({rv1, busy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL hs_release: valid/busy=%b, required 00", {rv1, busy1});
        end
        @(negedge clk);
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_start_ignored: busy=%0b, required 0", busy1);
        end
    endtask

    task automatic test_reset_mid();
        int acc, lat;
        wait_idle();
        start = 1;
        @(negedge clk);
        start = 0;
        spike_in = 4'hF;
        repeat (5) @(negedge clk);
        rst = 0;
        #1;
        n_cmp++;
        if ({busy1, rv1, net_clear1, idx1, cnt1, tie1, busy2, cnt2} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h, required 0",
                     {busy1, rv1, net_clear1, idx1, cnt1, tie1, busy2, cnt2});
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy1, cnt1, tie1} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h, required 0", {busy1, cnt1, tie1});
        end
        rst = 1;
        spike_in = '0;
        @(negedge clk);
        run(4'b0000, 0, 4'b0000, 0, acc, lat);
        n_cmp++;
        if (lat !== 15) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d, required 15", lat);
        end
        n_cmp++;
        if ({idx1, cnt1, tie1} !== {2'd0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_result: idx=%0d cnt=%0d tie=%0b, required 0/0/1", idx1, cnt1, tie1);
        end
    endtask

`ifdef IF_DECODER_EARLY_EXIT_EN
    task automatic test_early_exit();
        int lat = 0;
        wait_idle();
        spike_in = 4'b0010;
        start3 = 1;
        @(negedge clk);
        start3 = 0;
        while (!rv3 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        spike_in = '0;
        n_cmp++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL early_latency: got %0d, required 8", lat);
        end
        n_cmp++;
        if ({idx3, cnt3, tie3, ee3} !== {2'd1, 8'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL early_result: idx=%0d cnt=%0d tie=%0b ee=%0b, required 1/3/0/1",
                     idx3, cnt3, tie3, ee3);
        end
        n_cmp++;
        if (ee1 !== 1'b0) begin
            n_fail++;
            $display("FAIL early_flag_normal: ee=%0b, required 0", ee1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_winner();
        test_back_to_back();
        test_saturation();
        test_handshake();
        test_reset_mid();
`ifdef IF_DECODER_EARLY_EXIT_EN
        test_early_exit();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
